// File: rtl/pkg_sfrs_definition.sv
// rtl/pkg_sfrs_definition.sv - timer SFR word layout and delay-arbiter state type
package pkg_sfrs_definition;

  localparam int TMR_CTRL_W = 32;

  // Timer control word; low bits are the command strobes, the rest is reserved
  typedef struct packed {
    logic [TMR_CTRL_W-6:0] rsvd;
    logic                  count_en;
    logic                  stop;
    logic                  start;
    logic                  rst;
    logic                  on;
  } tmr_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } tmr_arb_state_t;

  // Control word the arbiter presents to the timer while sitting in a given state
  function automatic tmr_ctrl_t ctrl_word(input tmr_arb_state_t st, input logic first_run);
    tmr_ctrl_t c;
    c = '0;
    case (st)
      LOAD: begin
        c.on  = 1'b1;
        c.rst = 1'b1;
      end
      RUN: begin
        c.on       = 1'b1;
        c.count_en = 1'b1;
        c.start    = first_run;
      end
      STOP: begin
        c.on   = 1'b1;
        c.stop = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// rtl/rr_arbiter_nreq.sv - combinational round-robin pick starting at a pointer
module rr_arbiter_nreq #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] pointer,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] index,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] w_j;

  // Walk the requesters from pointer upward (wrapping) and take the first one set
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = IDX_W'((int'(pointer) + k) % N_REQ);
      if (!any && req[w_j]) begin
        any        = 1'b1;
        grant[w_j] = 1'b1;
        index      = w_j;
      end
    end
  end

endmodule

// File: rtl/tmr_delay_arbiter.sv
// rtl/tmr_delay_arbiter.sv - shares one timer between requesters needing one-shot delays
module tmr_delay_arbiter
  import pkg_sfrs_definition::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_delay,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              done,
  output logic                          done_err,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [DATA_WIDTH-1:0]         tmr_ctrl_o,
  output logic [DATA_WIDTH-1:0]         tmr_val_o,
  output logic [DATA_WIDTH-1:0]         tmr_match_val0_o,
  input  logic                          match0_event,
  input  logic                          ovf_event
);

  localparam int IDX_W = $clog2(N_REQ);

  tmr_arb_state_t        r_state;
  tmr_arb_state_t        w_next;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_gid;
  logic [DATA_WIDTH-1:0] r_match;
  logic                  r_err;
  logic                  r_first;

  logic [N_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]      w_index;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_set_err;
  logic [DATA_WIDTH-1:0] w_delays [N_REQ];
  logic [DATA_WIDTH-1:0] w_delay;
  tmr_ctrl_t             w_ctrl;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_delays[gi] = req_delay[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter_nreq #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid),
    .pointer (r_ptr),
    .grant   (w_grant),
    .index   (w_index),
    .any     (w_any)
  );

  assign w_delay   = w_delays[w_index];
  // Accept is held off during reset so every output reads 0 while sys_rst is high
  assign w_accept  = (r_state == IDLE) && w_any && !sys_rst;
  // Events only count in RUN; a match in the same cycle as an overflow wins
  assign w_set_err = (r_state == RUN) && ovf_event && !match0_event;

  assign busy             = (r_state != IDLE);
  assign grant_id         = r_gid;
  assign tmr_match_val0_o = r_match;
  assign tmr_val_o        = '0;
  assign tmr_ctrl_o       = DATA_WIDTH'(w_ctrl);

  // Next-state decode plus the handshake/done strobes for the current state
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    done      = '0;
    done_err  = 1'b0;
    w_ctrl    = ctrl_word(r_state, r_first);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready = w_grant;
          w_next    = (w_delay != '0) ? LOAD : STOP;
        end
      end
      LOAD: w_next = RUN;
      RUN: begin
        if (match0_event || ovf_event) w_next = STOP;
      end
      STOP: begin
        done[r_gid] = 1'b1;
        done_err    = r_err;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Grant bookkeeping: pointer, latched delay/index, first-RUN marker, error flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_ptr   <= '0;
      r_gid   <= '0;
      r_match <= '0;
      r_err   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (w_accept) begin
        r_match <= w_delay;
        r_gid   <= w_index;
        r_ptr   <= (w_index == IDX_W'(N_REQ-1)) ? '0 : w_index + 1'b1;
      end
      r_first <= (r_state == LOAD);
      if (w_set_err)              r_err <= 1'b1;
      else if (r_state == STOP)   r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmr_delay_arbiter.sv
// tb/tb_tmr_delay_arbiter.sv - self-checking bench for tmr_delay_arbiter
module tb_tmr_delay_arbiter;
  import pkg_sfrs_definition::*;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [DW-1:0] dly_in [N] = '{default: '0};
  logic [N*DW-1:0] req_delay;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  done;
  logic          done_err;
  logic          busy;
  logic [1:0]    grant_id;
  logic [DW-1:0] tmr_ctrl_o;
  logic [DW-1:0] tmr_val_o;
  logic [DW-1:0] tmr_match_val0_o;
  logic          match0_event;
  logic          ovf_event;
  logic          inj_m0 = 1'b0;
  logic          inj_ovf = 1'b0;
  logic [DW-1:0] tv = '0;
  tmr_ctrl_t     ctrl;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_mis = 0;

  assign req_delay = {dly_in[3], dly_in[2], dly_in[1], dly_in[0]};
  assign ctrl      = tmr_ctrl_t'(tmr_ctrl_o);

  tmr_delay_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .req_valid        (req_valid),
    .req_delay        (req_delay),
    .req_ready        (req_ready),
    .done             (done),
    .done_err         (done_err),
    .busy             (busy),
    .grant_id         (grant_id),
    .tmr_ctrl_o       (tmr_ctrl_o),
    .tmr_val_o        (tmr_val_o),
    .tmr_match_val0_o (tmr_match_val0_o),
    .match0_event     (match0_event),
    .ovf_event        (ovf_event)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Timer model: cleared by ctrl.rst, counts while count_en, compares against match-0
  always @(posedge sys_clk) begin
    if (sys_rst || ctrl.rst) tv <= '0;
    else if (ctrl.count_en)  tv <= tv + 1'b1;
  end
  assign match0_event = (tv == tmr_match_val0_o) | inj_m0;
  assign ovf_event    = inj_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[2'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int k = 0; k < N; k++)
      if (v[2'(k)]) return k;
    return -1;
  endfunction

  // Scoreboard: expectation pushed at accept, popped and compared on done
  typedef struct {
    int id;
    int acc;
    int dly;
    int due;
    bit err;
    bit resolved;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   m_ptr  = 0;
  int   m_free = 0;
  int   m_g;
  bit   m_idle;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      sb.delete();
      m_ptr  = 0;
      m_free = cyc + 1;
    end else begin
      if (sb.size() > 0 && !sb[0].resolved && cyc >= sb[0].acc + 2 &&
          cyc <= sb[0].acc + 2 + sb[0].dly && (match0_event || ovf_event)) begin
        e          = sb[0];
        e.due      = cyc + 1;
        e.err      = ovf_event && !match0_event;
        e.resolved = 1'b1;
        sb[0]      = e;
      end
      if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
        chk("sb_grant_id", grant_id, sb[0].id);
        chk("sb_match_val", tmr_match_val0_o, sb[0].dly);
      end
      if (|done) begin
        if (sb.size() == 0) chk("done_unexpected", done, 0);
        else begin
          e = sb.pop_front();
          chk("sb_done_id", done, 1 << e.id);
          chk("sb_done_cycle", cyc, e.due);
          chk("sb_done_err", done_err, e.err);
          m_free = cyc + 1;
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        chk("sb_done_missing", done, 1 << e.id);
        m_free = cyc + 1;
      end
      if (!(|done) && done_err) chk("done_err_stray", done_err, 0);
      m_idle = (sb.size() == 0) && (cyc >= m_free);
      chk("sb_busy", busy, !m_idle);
      if (m_idle && |req_valid) begin
        m_g = rr_pick(req_valid, m_ptr);
        chk("sb_ready", req_ready, 1 << m_g);
        e.id       = m_g;
        e.acc      = cyc;
        e.dly      = int'(dly_in[2'(m_g)]);
        e.due      = (e.dly == 0) ? cyc + 1 : cyc + 3 + e.dly;
        e.err      = 1'b0;
        e.resolved = (e.dly == 0);
        sb.push_back(e);
        m_ptr = (m_g + 1) % N;
      end else if (|req_ready) begin
        chk("ready_stray", req_ready, 0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] d);
    foreach (dly_in[i]) dly_in[i] = d;
  endtask

  task automatic wait_accept(output int acc, output int g);
    acc = -1;
    g   = -1;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (|req_ready) begin
        acc = cyc;
        g   = onehot_idx(req_ready);
        return;
      end
      next_cycle();
    end
    chk("accept_timeout", req_ready, req_valid);
  endtask

  task automatic wait_done(output int dc, output logic [3:0] dv, output logic de);
    dc = -1;
    dv = '0;
    de = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (|done) begin
        dc = cyc;
        dv = done;
        de = done_err;
        return;
      end
      next_cycle();
    end
    chk("done_timeout", done, 4'b1111);
  endtask

  typedef struct {
    logic [3:0]    valid;
    logic [DW-1:0] dly;
    bit            ovf;
    bit            m0;
    int            exp_grant;
    bit            exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    int         acc, g, dc, prev, lat;
    logic [3:0] dv;
    logic       de;
    logic       seen;
    int         rr_exp [5];

    vt[0] = '{4'b0100, 32'd3,  1'b0, 1'b0, 2, 1'b0};
    vt[1] = '{4'b0011, 32'd1,  1'b0, 1'b0, 0, 1'b0};
    vt[2] = '{4'b0011, 32'd7,  1'b0, 1'b0, 1, 1'b0};
    vt[3] = '{4'b1001, 32'd10, 1'b1, 1'b0, 3, 1'b1};
    vt[4] = '{4'b1001, 32'd10, 1'b1, 1'b1, 0, 1'b0};
    vt[5] = '{4'b0100, 32'd0,  1'b0, 1'b0, 2, 1'b0};
    vt[6] = '{4'b1110, 32'd4,  1'b0, 1'b0, 3, 1'b0};
    vt[7] = '{4'b1110, 32'd2,  1'b0, 1'b0, 1, 1'b0};
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) next_cycle();
    #2;
    chk("rst_ports", {req_ready, done, done_err, busy, grant_id}, 0);
    chk("rst_ctrl", tmr_ctrl_o, 0);
    chk("rst_match", tmr_match_val0_o, 0);
    chk("rst_val", tmr_val_o, 0);
    next_cycle();
    sys_rst = 1'b0;

    // Single request, delay 5
    next_cycle();
    req_valid = 4'b0001;
    dly_in[0] = 32'd5;
    wait_accept(acc, g);
    chk("t1_ready", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    #2;
    chk("t1_load_on_rst", {ctrl.on, ctrl.rst, ctrl.count_en}, 3'b110);
    next_cycle();
    #2;
    chk("t1_run_start", {ctrl.on, ctrl.count_en, ctrl.start}, 3'b111);
    next_cycle();
    #2;
    chk("t1_run_nostart", {ctrl.count_en, ctrl.start}, 2'b10);
    next_cycle();
    wait_done(dc, dv, de);
    chk("t1_done_cycle", dc - acc, 8);
    chk("t1_done", {dv, de}, 5'b00010);
    chk("t1_stop_ctrl", {ctrl.on, ctrl.stop, ctrl.count_en}, 3'b110);
    next_cycle();

    // Vector table: single transactions with optional overflow injection
    for (int v = 0; v < 8; v++) begin
      next_cycle();
      req_valid = vt[v].valid;
      set_all(vt[v].dly);
      wait_accept(acc, g);
      chk("vec_grant", g, vt[v].exp_grant);
      next_cycle();
      req_valid = '0;
      if (vt[v].ovf) begin
        next_cycle();
        next_cycle();
        inj_ovf = 1'b1;
        inj_m0  = vt[v].m0;
        next_cycle();
        inj_ovf = 1'b0;
        inj_m0  = 1'b0;
      end
      wait_done(dc, dv, de);
      lat = vt[v].ovf ? 4 : ((vt[v].dly == 0) ? 1 : int'(vt[v].dly) + 3);
      chk("vec_done_id", dv, 1 << vt[v].exp_grant);
      chk("vec_done_err", de, vt[v].exp_err);
      chk("vec_latency", dc - acc, lat);
      next_cycle();
    end

    // Zero delay: done next cycle, timer never counts
    next_cycle();
    req_valid = 4'b0100;
    set_all(32'd0);
    wait_accept(acc, g);
    chk("z_ready", req_ready, 4'b0100);
    chk("z_ce0", ctrl.count_en, 0);
    next_cycle();
    req_valid = '0;
    #2;
    chk("z_done", {done, done_err}, 5'b01000);
    chk("z_ce1", ctrl.count_en, 0);
    next_cycle();
    #2;
    chk("z_idle", {busy, ctrl.count_en}, 2'b00);

    // Reset during RUN, then pending requester 3 with pointer back at 0
    next_cycle();
    req_valid = 4'b0001;
    set_all(32'd20);
    wait_accept(acc, g);
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    #2;
    chk("mr_ports", {req_ready, done, done_err, busy, grant_id}, 0);
    chk("mr_ctrl", tmr_ctrl_o, 0);
    chk("mr_match", tmr_match_val0_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      #2;
      seen = seen | (|done);
    end
    chk("mr_no_done", seen, 0);
    next_cycle();
    req_valid = 4'b1000;
    set_all(32'd3);
    wait_accept(acc, g);
    chk("mr_grant3", g, 3);
    next_cycle();
    req_valid = '0;
    #2;
    chk("mr_grant_id", grant_id, 3);
    next_cycle();
    wait_done(dc, dv, de);
    chk("mr_done", dv, 4'b1000);
    next_cycle();

    // Round-robin with all requesters held valid
    next_cycle();
    req_valid = 4'b1111;
    set_all(32'd2);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_accept(acc, g);
      chk("rr_order", g, rr_exp[i]);
      if (i > 0) chk("rr_spacing", acc - prev, 6);
      prev = acc;
      next_cycle();
    end
    req_valid = '0;
    wait_done(dc, dv, de);
    chk("rr_last_done", dv, 4'b0001);
    next_cycle();

    // Valid withdrawal while busy, stale match during LOAD
    next_cycle();
    req_valid = 4'b0001;
    set_all(32'd8);
    wait_accept(acc, g);
    next_cycle();
    req_valid = '0;
    inj_m0    = 1'b1;
    next_cycle();
    inj_m0    = 1'b0;
    req_valid = 4'b0010;
    next_cycle();
    req_valid = '0;
    wait_done(dc, dv, de);
    chk("wd_done", {dv, de}, 5'b00010);
    chk("wd_latency", dc - acc, 11);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      #2;
      seen = seen | req_ready[1] | done[1];
    end
    chk("wd_no_req1", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
